// File: rtl/jtag_scan_master_if.sv
// jtag_scan_master_if: command, result and TAP-pin bundle for jtag_scan_master.
// Signal names are given from the engine's point of view.
//   i_start/i_cmd/i_len/i_din : command strobe, opcode, scan length and shift data
//   i_runtest                 : idle cycles after UPDATE (only with JTAG_RUNTEST_EN)
//   i_tdo_in                  : TDO returned by the target TAP
//   o_tms/o_tdi_out           : registered TMS/TDI driven to the target
//   o_busy/o_done/o_err       : status, one-cycle completion and reject pulses
//   o_dout                    : captured TDO bits, bit 0 captured first
// Modports: master = host/target side, slave = the scan engine.
// Optional feature macro: JTAG_RUNTEST_EN.
interface jtag_scan_master_if #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned LEN_W   = 6
);
    logic               i_start;
    logic [1:0]         i_cmd;
    logic [LEN_W-1:0]   i_len;
    logic [MAX_LEN-1:0] i_din;
`ifdef JTAG_RUNTEST_EN
    logic [7:0]         i_runtest;
`endif
    logic               i_tdo_in;
    logic               o_tms;
    logic               o_tdi_out;
    logic               o_busy;
    logic               o_done;
    logic               o_err;
    logic [MAX_LEN-1:0] o_dout;

    modport master (
`ifdef JTAG_RUNTEST_EN
        output i_runtest,
`endif
        output i_start, i_cmd, i_len, i_din, i_tdo_in,
        input  o_tms, o_tdi_out, o_busy, o_done, o_err, o_dout
    );

    modport slave (
`ifdef JTAG_RUNTEST_EN
        input  i_runtest,
`endif
        input  i_start, i_cmd, i_len, i_din, i_tdo_in,
        output o_tms, o_tdi_out, o_busy, o_done, o_err, o_dout
    );
endinterface

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: converts parallel IR/DR scan and TAP-reset commands into TMS/TDI
// bit streams and collects TDO into a parallel result word.
// Ports:
//   i_tck  : scan clock, all logic on the rising edge
//   i_trst : asynchronous active-high reset
//   bus    : jtag_scan_master_if.slave (command, result and TAP pins)
// Optional feature macro: JTAG_RUNTEST_EN adds RUNTEST idle cycles after UPDATE.
// Parameters must match those of the connected interface; RESET_CYCLES must be
// at least 1 and below 2**LEN_W.
module jtag_scan_master #(
    parameter int unsigned MAX_LEN      = 32,
    parameter int unsigned LEN_W        = 6,
    parameter int unsigned RESET_CYCLES = 5
) (
    input logic             i_tck,
    input logic             i_trst,
    jtag_scan_master_if.slave bus
);
    typedef enum logic [3:0] {
        StTlr, StRti, StSelDr, StSelIr, StCapture, StShift, StExit1, StUpdate, StRstSeq
    } state_e;

    localparam logic [1:0]       CmdIr   = 2'b01;
    localparam logic [1:0]       CmdRst  = 2'b10;
    localparam logic [1:0]       CmdRsvd = 2'b11;
    localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RstCycW = LEN_W'(RESET_CYCLES);
    localparam logic [LEN_W-1:0] OneW    = LEN_W'(1);

    state_e             r_state, w_state_d;
    logic               r_tms, w_tms_d;
    logic               r_tdi, w_tdi_d;
    logic               r_busy, w_busy_d;
    logic               r_done, w_done_d;
    logic               r_err, w_err_d;
    logic               r_rej, w_rej_d;
    logic [1:0]         r_cmd, w_cmd_d;
    logic [LEN_W-1:0]   r_len, w_len_d;
    logic [LEN_W-1:0]   r_cnt, w_cnt_d;
    logic [MAX_LEN-1:0] r_din, w_din_d;
    logic [MAX_LEN-1:0] r_bit, w_bit_d;   // one-hot DOUT position of the next capture
    logic [MAX_LEN-1:0] r_dout, w_dout_d;
`ifdef JTAG_RUNTEST_EN
    logic [7:0]         r_rt, w_rt_d;
    logic [7:0]         r_rt_cnt, w_rt_cnt_d;
`endif
    logic               w_invalid;

    assign w_invalid = (bus.i_cmd == CmdRsvd) || (bus.i_len == '0) || (bus.i_len > MaxLenW);

    always_ff @(posedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            r_state  <= StTlr;
            r_tms    <= 1'b1;
            r_tdi    <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rej    <= 1'b0;
            r_cmd    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_din    <= '0;
            r_bit    <= '0;
            r_dout   <= '0;
`ifdef JTAG_RUNTEST_EN
            r_rt     <= '0;
            r_rt_cnt <= '0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_tms    <= w_tms_d;
            r_tdi    <= w_tdi_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_err    <= w_err_d;
            r_rej    <= w_rej_d;
            r_cmd    <= w_cmd_d;
            r_len    <= w_len_d;
            r_cnt    <= w_cnt_d;
            r_din    <= w_din_d;
            r_bit    <= w_bit_d;
            r_dout   <= w_dout_d;
`ifdef JTAG_RUNTEST_EN
            r_rt     <= w_rt_d;
            r_rt_cnt <= w_rt_cnt_d;
`endif
        end
    end

    // Tracked state follows the TMS value the target samples at this edge.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StTlr:     w_state_d = r_tms ? StTlr : StRti;
            StRstSeq:  w_state_d = r_tms ? StRstSeq : StRti;
            StRti:     if (r_tms) w_state_d = (r_cmd == CmdRst) ? StRstSeq : StSelDr;
            StSelDr:   w_state_d = r_tms ? StSelIr : StCapture;
            StSelIr:   w_state_d = r_tms ? StTlr : StCapture;
            StCapture: w_state_d = r_tms ? StExit1 : StShift;
            StShift:   w_state_d = r_tms ? StExit1 : StShift;
            StExit1:   w_state_d = StUpdate;  // engine always drives TMS=1 here
            StUpdate:  w_state_d = r_tms ? StSelDr : StRti;
            default:   w_state_d = StTlr;
        endcase
    end

    // Next values of TMS/TDI, status and datapath, keyed on the state being entered.
    always_comb begin
        w_tms_d    = 1'b0;
        w_tdi_d    = 1'b0;
        w_busy_d   = r_busy;
        w_done_d   = 1'b0;
        w_err_d    = 1'b0;
        w_rej_d    = 1'b0;
        w_cmd_d    = r_cmd;
        w_len_d    = r_len;
        w_cnt_d    = r_cnt;
        w_din_d    = r_din;
        w_bit_d    = r_bit;
        w_dout_d   = r_dout;
`ifdef JTAG_RUNTEST_EN
        w_rt_d     = r_rt;
        w_rt_cnt_d = r_rt_cnt;
`endif
        // Every edge spent in SHIFT captures one TDO bit and advances the data.
        if (r_state == StShift) begin
            w_dout_d = r_dout | (r_bit & {MAX_LEN{bus.i_tdo_in}});
            w_bit_d  = r_bit << 1;
            w_din_d  = r_din >> 1;
            w_cnt_d  = r_cnt + OneW;
        end
        case (w_state_d)
            StRstSeq: begin
                w_cnt_d = r_cnt + OneW;
                w_tms_d = (w_cnt_d < RstCycW);
            end
            StSelDr: w_tms_d = (r_cmd == CmdIr);
            StShift: begin
                w_tdi_d = w_din_d[0];
                w_tms_d = (w_cnt_d == r_len - OneW);
            end
            StExit1: w_tms_d = 1'b1;
            StRti: begin
                if (r_state != StRti) begin
                    if (r_state == StTlr) begin
                        w_busy_d = 1'b0;
                    end
`ifdef JTAG_RUNTEST_EN
                    else if ((r_state == StUpdate) && (r_rt != 8'd0)) begin
                        w_rt_cnt_d = 8'd1;
                    end
`endif
                    else begin
                        w_busy_d = 1'b0;
                        w_done_d = 1'b1;
                    end
                end else if (!r_busy) begin
                    if (bus.i_start) begin
                        w_busy_d = 1'b1;
                        w_cmd_d  = bus.i_cmd;
                        w_len_d  = bus.i_len;
                        w_din_d  = bus.i_din;
                        w_dout_d = '0;
                        w_cnt_d  = '0;
                        w_bit_d  = MAX_LEN'(1);
`ifdef JTAG_RUNTEST_EN
                        w_rt_d   = bus.i_runtest;
`endif
                        if (w_invalid) w_rej_d = 1'b1;
                        else           w_tms_d = 1'b1;
                    end
                end else if (r_rej) begin
                    w_busy_d = 1'b0;
                    w_done_d = 1'b1;
                    w_err_d  = 1'b1;
                end
`ifdef JTAG_RUNTEST_EN
                else if (r_rt_cnt == r_rt) begin
                    w_busy_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    w_rt_cnt_d = r_rt_cnt + 8'd1;
                end
`endif
            end
            default: ;
        endcase
    end

    assign bus.o_tms     = r_tms;
    assign bus.o_tdi_out = r_tdi;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_err     = r_err;
    assign bus.o_dout    = r_dout;
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: directed bench for jtag_scan_master driving a behavioural
// target TAP with a 4-bit IR, a 32-bit IDCODE register and a 1-bit BYPASS register.
module tb_jtag_scan_master;
    localparam logic [31:0] IdValue = 32'h1234_5677;
    localparam logic [3:0]  OpIdcode = 4'b1110;
    localparam logic [3:0]  OpBypass = 4'b1111;

    // Target TAP state encoding.
    localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SDR = 4'd2, CDR = 4'd3, SHDR = 4'd4,
                           E1DR = 4'd5, PDR = 4'd6, E2DR = 4'd7, UDR = 4'd8, SIR = 4'd9,
                           CIR = 4'd10, SHIR = 4'd11, E1IR = 4'd12, PIR = 4'd13,
                           E2IR = 4'd14, UIR = 4'd15;

    logic tck = 1'b0;
    logic trst = 1'b1;
    always #5 tck = ~tck;

    jtag_scan_master_if #(.MAX_LEN(32), .LEN_W(6)) bus ();

    jtag_scan_master #(.MAX_LEN(32), .LEN_W(6), .RESET_CYCLES(5)) dut (
        .i_tck  (tck),
        .i_trst (trst),
        .bus    (bus)
    );

    // Behavioural target TAP.
    logic [3:0]  t_state;
    logic [3:0]  t_ir;
    logic [3:0]  t_ir_sr;
    logic [31:0] t_dr_sr;

    function automatic logic [3:0] tap_nx(input logic [3:0] s, input logic m);
        case (s)
            TLR:     return m ? TLR : RTI;
            RTI:     return m ? SDR : RTI;
            SDR:     return m ? SIR : CDR;
            CDR:     return m ? E1DR : SHDR;
            SHDR:    return m ? E1DR : SHDR;
            E1DR:    return m ? UDR : PDR;
            PDR:     return m ? E2DR : PDR;
            E2DR:    return m ? UDR : SHDR;
            UDR:     return m ? SDR : RTI;
            SIR:     return m ? TLR : CIR;
            CIR:     return m ? E1IR : SHIR;
            SHIR:    return m ? E1IR : SHIR;
            E1IR:    return m ? UIR : PIR;
            PIR:     return m ? E2IR : PIR;
            E2IR:    return m ? UIR : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    always @(posedge tck or posedge trst) begin
        if (trst) begin
            t_state <= TLR;
            t_ir    <= OpIdcode;
            t_ir_sr <= 4'b0;
            t_dr_sr <= 32'b0;
        end else begin
            case (t_state)
                TLR:  t_ir <= OpIdcode;
                CDR:  t_dr_sr <= (t_ir == OpIdcode) ? IdValue : 32'b0;
                SHDR: t_dr_sr <= (t_ir == OpIdcode) ? {bus.o_tdi_out, t_dr_sr[31:1]}
                                                    : {31'b0, bus.o_tdi_out};
                CIR:  t_ir_sr <= 4'b0001;
                SHIR: t_ir_sr <= {bus.o_tdi_out, t_ir_sr[3:1]};
                UIR:  t_ir <= t_ir_sr;
                default: ;
            endcase
            t_state <= tap_nx(t_state, bus.o_tms);
        end
    end

    assign bus.i_tdo_in = (t_state == SHDR) ? t_dr_sr[0] : (t_state == SHIR) ? t_ir_sr[0] : 1'b0;

    // TMS as sampled by the target, first sampled bit ends up most significant.
    logic        rec = 1'b0;
    logic [63:0] tms_log;
    int          rec_n;
    always @(posedge tck) begin
        if (!rec) begin
            tms_log <= 64'b0;
            rec_n   <= 0;
        end else begin
            tms_log <= {tms_log[62:0], bus.o_tms};
            rec_n   <= rec_n + 1;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    // Issue one command and count edges after the START-sampling edge until DONE.
    task automatic run_cmd(input logic [1:0] c, input logic [5:0] l, input logic [31:0] d,
                           output int edges, output logic err_at_done,
                           output logic busy_at_done, output logic busy_after_start);
        @(negedge tck);
        bus.i_cmd = c;
        bus.i_len = l;
        bus.i_din = d;
        bus.i_start = 1'b1;
        @(posedge tck);
        #1;
        bus.i_start = 1'b0;
        busy_after_start = bus.o_busy;
        rec = 1'b1;
        edges = -1;
        err_at_done = 1'bx;
        busy_at_done = 1'bx;
        for (int i = 1; i <= 100; i++) begin
            @(posedge tck);
            #1;
            if (bus.o_done) begin
                edges = i;
                err_at_done = bus.o_err;
                busy_at_done = bus.o_busy;
                break;
            end
        end
        rec = 1'b0;
    endtask

    task automatic test_reset();
        trst = 1'b1;
        repeat (3) @(posedge tck);
        #1;
        n_total++; if (bus.o_tms !== 1'b1) $display("FAIL rst_tms got %b exp 1", bus.o_tms); else n_pass++;
        n_total++; if (bus.o_busy !== 1'b1) $display("FAIL rst_busy got %b exp 1", bus.o_busy); else n_pass++;
        n_total++; if (bus.o_done !== 1'b0 || bus.o_err !== 1'b0)
            $display("FAIL rst_done_err got %b%b exp 00", bus.o_done, bus.o_err); else n_pass++;
        n_total++; if (bus.o_dout !== 32'h0 || bus.o_tdi_out !== 1'b0)
            $display("FAIL rst_dout_tdi got %h/%b exp 0/0", bus.o_dout, bus.o_tdi_out); else n_pass++;
        @(negedge tck);
        trst = 1'b0;
        @(posedge tck);
        #1;
        n_total++; if (bus.o_tms !== 1'b0 || bus.o_busy !== 1'b1)
            $display("FAIL rst_edge1 got tms=%b busy=%b exp 0 1", bus.o_tms, bus.o_busy); else n_pass++;
        @(posedge tck);
        #1;
        n_total++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0)
            $display("FAIL rst_edge2 got busy=%b done=%b exp 0 0", bus.o_busy, bus.o_done); else n_pass++;
    endtask

    task automatic test_dr_idcode();
        int e; logic er, bd, bs;
        run_cmd(2'b00, 6'd32, 32'hA5A5_1234, e, er, bd, bs);
        n_total++; if (e !== 37) $display("FAIL dr32_latency got %0d exp 37", e); else n_pass++;
        n_total++; if (bus.o_dout !== IdValue) $display("FAIL dr32_dout got %h exp %h", bus.o_dout, IdValue); else n_pass++;
        n_total++; if (er !== 1'b0 || bd !== 1'b0 || bs !== 1'b1)
            $display("FAIL dr32_status got err=%b busy=%b busy0=%b exp 0 0 1", er, bd, bs); else n_pass++;
        n_total++; if (rec_n !== 37 || tms_log !== {27'b0, 3'b100, 31'b0, 3'b110})
            $display("FAIL dr32_tms got n=%0d log=%h", rec_n, tms_log); else n_pass++;
        n_total++; if (t_dr_sr !== 32'hA5A5_1234) $display("FAIL dr32_tdi got %h exp a5a51234", t_dr_sr); else n_pass++;
        @(posedge tck);
        #1;
        n_total++; if (bus.o_done !== 1'b0 || bus.o_dout !== IdValue)
            $display("FAIL dr32_pulse got done=%b dout=%h", bus.o_done, bus.o_dout); else n_pass++;
    endtask

    task automatic test_ir_scan();
        int e; logic er, bd, bs;
        run_cmd(2'b01, 6'd4, {28'b0, OpIdcode}, e, er, bd, bs);
        n_total++; if (e !== 10) $display("FAIL ir4_latency got %0d exp 10", e); else n_pass++;
        n_total++; if (bus.o_dout !== 32'h1) $display("FAIL ir4_dout got %h exp 00000001", bus.o_dout); else n_pass++;
        n_total++; if (rec_n !== 10 || tms_log !== {54'b0, 10'b1100000110})
            $display("FAIL ir4_tms got n=%0d log=%h", rec_n, tms_log); else n_pass++;
        n_total++; if (t_ir !== OpIdcode) $display("FAIL ir4_tdi got %b exp %b", t_ir, OpIdcode); else n_pass++;
    endtask

    task automatic test_bypass();
        int e; logic er, bd, bs;
        run_cmd(2'b01, 6'd4, {28'b0, OpBypass}, e, er, bd, bs);
        n_total++; if (t_ir !== OpBypass) $display("FAIL byp_ir got %b exp %b", t_ir, OpBypass); else n_pass++;
        run_cmd(2'b00, 6'd8, 32'h0000_00C3, e, er, bd, bs);
        n_total++; if (e !== 13) $display("FAIL byp_latency got %0d exp 13", e); else n_pass++;
        n_total++; if (bus.o_dout !== 32'h0000_0086) $display("FAIL byp_dout got %h exp 00000086", bus.o_dout); else n_pass++;
        n_total++; if (rec_n !== 13 || tms_log !== {51'b0, 3'b100, 7'b0, 3'b110})
            $display("FAIL byp_tms got n=%0d log=%h", rec_n, tms_log); else n_pass++;
    endtask

    task automatic test_reject();
        int e; logic er, bd, bs;
        run_cmd(2'b00, 6'd0, 32'hFFFF_FFFF, e, er, bd, bs);
        n_total++; if (e !== 1 || er !== 1'b1 || bs !== 1'b1 || bd !== 1'b0)
            $display("FAIL rej_len0 got e=%0d err=%b busy0=%b busy=%b exp 1 1 1 0", e, er, bs, bd); else n_pass++;
        n_total++; if (rec_n !== 1 || tms_log !== 64'b0 || bus.o_tms !== 1'b0)
            $display("FAIL rej_len0_tms got n=%0d log=%h tms=%b", rec_n, tms_log, bus.o_tms); else n_pass++;
        run_cmd(2'b11, 6'd8, 32'h0, e, er, bd, bs);
        n_total++; if (e !== 1 || er !== 1'b1 || bs !== 1'b1)
            $display("FAIL rej_cmd11 got e=%0d err=%b busy0=%b exp 1 1 1", e, er, bs); else n_pass++;
        n_total++; if (tms_log !== 64'b0) $display("FAIL rej_cmd11_tms got log=%h exp 0", tms_log); else n_pass++;
        run_cmd(2'b00, 6'd33, 32'h0, e, er, bd, bs);
        n_total++; if (e !== 1 || er !== 1'b1)
            $display("FAIL rej_len33 got e=%0d err=%b exp 1 1", e, er); else n_pass++;
        @(posedge tck);
        #1;
        n_total++; if (bus.o_err !== 1'b0 || bus.o_done !== 1'b0)
            $display("FAIL rej_pulse got err=%b done=%b exp 0 0", bus.o_err, bus.o_done); else n_pass++;
    endtask

    task automatic test_tap_reset();
        int e; logic er, bd, bs;
        run_cmd(2'b10, 6'd1, 32'h0, e, er, bd, bs);
        n_total++; if (e !== 6 || er !== 1'b0)
            $display("FAIL tapr_latency got e=%0d err=%b exp 6 0", e, er); else n_pass++;
        n_total++; if (rec_n !== 6 || tms_log !== {58'b0, 6'b111110})
            $display("FAIL tapr_tms got n=%0d log=%h", rec_n, tms_log); else n_pass++;
        n_total++; if (t_state !== RTI || t_ir !== OpIdcode)
            $display("FAIL tapr_target got st=%0d ir=%b exp 1 %b", t_state, t_ir, OpIdcode); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e1, e2;
        logic reacc;
        @(negedge tck);
        bus.i_cmd = 2'b00;
        bus.i_len = 6'd32;
        bus.i_din = 32'h0;
        bus.i_start = 1'b1;
        e1 = -1;
        for (int i = 0; i <= 100; i++) begin
            @(posedge tck);
            #1;
            if (bus.o_done) begin e1 = i; break; end
        end
        @(posedge tck);
        #1;
        reacc = bus.o_busy;
        bus.i_start = 1'b0;
        e2 = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge tck);
            #1;
            if (bus.o_done) begin e2 = i; break; end
        end
        n_total++; if (e1 !== 37) $display("FAIL b2b_first got %0d exp 37", e1); else n_pass++;
        n_total++; if (reacc !== 1'b1) $display("FAIL b2b_reaccept got busy=%b exp 1", reacc); else n_pass++;
        n_total++; if (e2 !== 37 || bus.o_dout !== IdValue)
            $display("FAIL b2b_second got e=%0d dout=%h exp 37 %h", e2, bus.o_dout, IdValue); else n_pass++;
    endtask

    task automatic test_trst_abort();
        int e; logic er, bd, bs;
        logic seen_done;
        @(negedge tck);
        bus.i_cmd = 2'b00;
        bus.i_len = 6'd32;
        bus.i_din = 32'h5555_AAAA;
        bus.i_start = 1'b1;
        @(posedge tck);
        #1;
        bus.i_start = 1'b0;
        repeat (13) @(posedge tck);
        #1;
        n_total++; if (bus.o_dout !== 32'h0000_0277 || bus.o_busy !== 1'b1)
            $display("FAIL abort_partial got dout=%h busy=%b exp 00000277 1", bus.o_dout, bus.o_busy); else n_pass++;
        trst = 1'b1;
        #1;
        n_total++; if (bus.o_tms !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_tdi_out !== 1'b0)
            $display("FAIL abort_pins got tms=%b busy=%b tdi=%b exp 1 1 0", bus.o_tms, bus.o_busy, bus.o_tdi_out); else n_pass++;
        n_total++; if (bus.o_dout !== 32'h0 || bus.o_done !== 1'b0 || bus.o_err !== 1'b0)
            $display("FAIL abort_out got dout=%h done=%b err=%b exp 0 0 0", bus.o_dout, bus.o_done, bus.o_err); else n_pass++;
        seen_done = 1'b0;
        repeat (3) begin
            @(posedge tck);
            #1;
            if (bus.o_done) seen_done = 1'b1;
        end
        @(negedge tck);
        trst = 1'b0;
        repeat (40) begin
            @(posedge tck);
            #1;
            if (bus.o_done) seen_done = 1'b1;
        end
        n_total++; if (seen_done !== 1'b0 || bus.o_busy !== 1'b0)
            $display("FAIL abort_nodone got done_seen=%b busy=%b exp 0 0", seen_done, bus.o_busy); else n_pass++;
        run_cmd(2'b00, 6'd32, 32'h0F0F_0F0F, e, er, bd, bs);
        n_total++; if (e !== 37 || bus.o_dout !== IdValue)
            $display("FAIL abort_rescan got e=%0d dout=%h exp 37 %h", e, bus.o_dout, IdValue); else n_pass++;
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_cmd = 2'b00;
        bus.i_len = 6'd0;
        bus.i_din = 32'h0;
`ifdef JTAG_RUNTEST_EN
        bus.i_runtest = 8'd0;
`endif
        test_reset();
        test_dr_idcode();
        test_ir_scan();
        test_bypass();
        test_reject();
        test_tap_reset();
        test_back_to_back();
        test_trst_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
